irq_controller: RTL and testbench

- Prioritising interrupt controller that replaces the ad-hoc interrupt latch/pending logic in the pipeline top level.
- Collects edge-triggered requests from NUM_SRC external sources (key, ethernet, …) and captures each source's data word at its request edge.
- Arbitrates by fixed priority and delivers one interrupt at a time to fetch/execute, only when the pipeline is safe (no memory op in flight, no flush).
- Holds the delivered data stable for RDI until the handler retires via RTI/RSI.

---
 rtl/irq_controller.sv | 104 ++++++++++
 tb/tb_irq_controller.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// Prioritising interrupt controller: edge-captures per-source requests and data,
// then delivers the highest-priority enabled request when the core is safe.
module irq_controller #(
  parameter int NUM_SRC = 2,
  parameter int DATA_W  = 32,
  parameter int OVF_W   = 8,
  localparam int ID_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_req,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        irq_en,
  input  logic                      core_busy,
  input  logic                      core_flush,
  input  logic                      svc_done,
  output logic                      irq,
  output logic [DATA_W-1:0]         irq_data,
  output logic [ID_W-1:0]           irq_id,
  output logic                      in_service,
  output logic [NUM_SRC-1:0]        pending,
  output logic [OVF_W-1:0]          ovf_count
);

  typedef enum logic [1:0] {IDLE, WAIT_SAFE, DELIVER, IN_SERVICE} state_t;

  state_t              state, state_nx;
  logic [NUM_SRC-1:0]  req_q, rise, eligible, clr, accept, drop;
  logic [DATA_W-1:0]   data_reg [NUM_SRC];
  logic [ID_W-1:0]     winner;
  logic                any_elig, sample;
  logic [OVF_W:0]      ovf_sum;
  logic [OVF_W-1:0]    ovf_nx;

  assign rise     = src_req & ~req_q;
  assign eligible = pending & irq_en;
  assign any_elig = |eligible;
  assign sample   = (state == WAIT_SAFE) && any_elig && !core_busy && !core_flush;
  assign clr      = sample ? (NUM_SRC'(1) << winner) : '0;

  // A rise in the very cycle its pending bit is being consumed is a fresh request.
  assign accept   = rise & (~pending | clr);
  assign drop     = rise & pending & ~clr;

  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end
  end

  always_comb begin
    ovf_sum = {1'b0, ovf_count};
    for (int i = 0; i < NUM_SRC; i++) begin
      ovf_sum = ovf_sum + (OVF_W + 1)'(drop[i]);
    end
    ovf_nx = ovf_sum[OVF_W] ? '1 : ovf_sum[OVF_W-1:0];
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       if (any_elig) state_nx = WAIT_SAFE;
      WAIT_SAFE: begin
        if (!any_elig)   state_nx = IDLE;
        else if (sample) state_nx = DELIVER;
      end
      DELIVER:    state_nx = IN_SERVICE;
      IN_SERVICE: if (svc_done) state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  assign irq        = (state == DELIVER);
  assign in_service = (state == DELIVER) || (state == IN_SERVICE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q     <= '0;
      pending   <= '0;
      ovf_count <= '0;
      irq_data  <= '0;
      irq_id    <= '0;
      for (int i = 0; i < NUM_SRC; i++) data_reg[i] <= '0;
    end else begin
      req_q     <= src_req;
      pending   <= (pending & ~clr) | accept;
      ovf_count <= ovf_nx;
      if (sample) begin
        irq_id   <= winner;
        irq_data <= data_reg[winner];
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (accept[i]) data_reg[i] <= src_data[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed vector table, hand-written corner sequences,
// and randomized traffic against a behavioural model of the delivery rules.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  src_req;
  logic [63:0] src_data;
  logic [1:0]  irq_en;
  logic        core_busy, core_flush, svc_done;
  logic        irq;
  logic [31:0] irq_data;
  logic [0:0]  irq_id;
  logic        in_service;
  logic [1:0]  pending;
  logic [7:0]  ovf_count;

  int n_vec = 0;
  int n_err = 0;

  irq_controller dut (
    .clk(clk), .rst(rst), .src_req(src_req), .src_data(src_data), .irq_en(irq_en),
    .core_busy(core_busy), .core_flush(core_flush), .svc_done(svc_done),
    .irq(irq), .irq_data(irq_data), .irq_id(irq_id), .in_service(in_service),
    .pending(pending), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    src_req    = '0;
    src_data   = '0;
    irq_en     = 2'b11;
    core_busy  = 1'b0;
    core_flush = 1'b0;
    svc_done   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_irq(input int max_cyc, input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (irq !== 1'b1 && n < max_cyc);
    chk(name, 64'(irq), 64'd1);
  endtask

  task automatic finish_service();
    tick();
    svc_done = 1'b1;
    tick();
    svc_done = 1'b0;
  endtask

  // ---------------- behavioural reference model ----------------
  bit          m_pend [2];
  logic [31:0] m_cap  [2];
  bit          m_prev [2];
  int          m_drops;
  bit          m_armed, m_pulse, m_serving;
  int          m_id;
  logic [31:0] m_data;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 0; m_cap[i] = '0; m_prev[i] = 0;
    end
    m_drops = 0; m_armed = 0; m_pulse = 0; m_serving = 0; m_id = 0; m_data = '0;
  endtask

  // Advance the model by one clock using the inputs presented for that edge.
  task automatic model_step();
    int win = -1;
    bit taken [2];
    taken[0] = 0; taken[1] = 0;
    for (int i = 0; i < 2; i++)
      if (m_pend[i] && irq_en[i] && win < 0) win = i;
    if (m_pulse) begin
      m_pulse = 0; m_serving = 1;
    end else if (m_serving) begin
      if (svc_done) m_serving = 0;
    end else if (m_armed) begin
      if (win < 0) m_armed = 0;
      else if (!core_busy && !core_flush) begin
        m_armed = 0; m_pulse = 1; m_id = win; m_data = m_cap[win]; taken[win] = 1;
      end
    end else if (win >= 0) begin
      m_armed = 1;
    end
    for (int i = 0; i < 2; i++) begin
      if (src_req[i] && !m_prev[i]) begin
        if (!m_pend[i] || taken[i]) begin
          m_pend[i] = 1; m_cap[i] = src_data[i*32 +: 32];
        end else begin
          m_drops = (m_drops < 255) ? m_drops + 1 : 255;
        end
      end else if (taken[i]) begin
        m_pend[i] = 0;
      end
      m_prev[i] = src_req[i];
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]  req;
    logic [31:0] d0, d1;
    logic        svc;
    logic        e_irq;
    logic        e_id;
    logic [31:0] e_data;
    logic        e_ins;
    logic [1:0]  e_pend;
  } vec_t;

  vec_t tbl [16];

  initial begin : watchdog
    #1000000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : main
    // single rise on source 1, then simultaneous rises on both sources
    tbl[0]  = '{2'b10, 32'h0,  32'hCAFE0001, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 2'b10};
    tbl[1]  = '{2'b10, 32'h0,  32'hCAFE0001, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 2'b10};
    tbl[2]  = '{2'b10, 32'h0,  32'hCAFE0001, 1'b0, 1'b1, 1'b1, 32'hCAFE0001, 1'b1, 2'b00};
    tbl[3]  = '{2'b10, 32'h0,  32'hCAFE0001, 1'b0, 1'b0, 1'b1, 32'hCAFE0001, 1'b1, 2'b00};
    tbl[4]  = '{2'b10, 32'h0,  32'hCAFE0001, 1'b1, 1'b0, 1'b1, 32'hCAFE0001, 1'b0, 2'b00};
    tbl[5]  = '{2'b00, 32'h0,  32'hCAFE0001, 1'b0, 1'b0, 1'b1, 32'hCAFE0001, 1'b0, 2'b00};
    tbl[6]  = '{2'b11, 32'h11, 32'h22,       1'b0, 1'b0, 1'b1, 32'hCAFE0001, 1'b0, 2'b11};
    tbl[7]  = '{2'b11, 32'h11, 32'h22,       1'b0, 1'b0, 1'b1, 32'hCAFE0001, 1'b0, 2'b11};
    tbl[8]  = '{2'b11, 32'h11, 32'h22,       1'b0, 1'b1, 1'b0, 32'h11,       1'b1, 2'b10};
    tbl[9]  = '{2'b11, 32'h11, 32'h22,       1'b0, 1'b0, 1'b0, 32'h11,       1'b1, 2'b10};
    tbl[10] = '{2'b11, 32'h11, 32'h22,       1'b1, 1'b0, 1'b0, 32'h11,       1'b0, 2'b10};
    tbl[11] = '{2'b11, 32'h11, 32'h22,       1'b0, 1'b0, 1'b0, 32'h11,       1'b0, 2'b10};
    tbl[12] = '{2'b11, 32'h11, 32'h22,       1'b0, 1'b1, 1'b1, 32'h22,       1'b1, 2'b00};
    tbl[13] = '{2'b11, 32'h11, 32'h22,       1'b1, 1'b0, 1'b1, 32'h22,       1'b1, 2'b00};
    tbl[14] = '{2'b11, 32'h11, 32'h22,       1'b1, 1'b0, 1'b1, 32'h22,       1'b0, 2'b00};
    tbl[15] = '{2'b00, 32'h11, 32'h22,       1'b0, 1'b0, 1'b1, 32'h22,       1'b0, 2'b00};

    do_reset();
    chk("reset_irq",   64'(irq),        64'd0);
    chk("reset_insvc", 64'(in_service), 64'd0);
    chk("reset_pend",  64'(pending),    64'd0);
    chk("reset_ovf",   64'(ovf_count),  64'd0);
    chk("reset_data",  64'(irq_data),   64'd0);
    chk("reset_id",    64'(irq_id),     64'd0);

    for (int r = 0; r < 16; r++) begin
      src_req  = tbl[r].req;
      src_data = {tbl[r].d1, tbl[r].d0};
      svc_done = tbl[r].svc;
      tick();
      chk($sformatf("tbl%0d_irq", r),   64'(irq),        64'(tbl[r].e_irq));
      chk($sformatf("tbl%0d_id", r),    64'(irq_id),     64'(tbl[r].e_id));
      chk($sformatf("tbl%0d_data", r),  64'(irq_data),   64'(tbl[r].e_data));
      chk($sformatf("tbl%0d_insvc", r), 64'(in_service), 64'(tbl[r].e_ins));
      chk($sformatf("tbl%0d_pend", r),  64'(pending),    64'(tbl[r].e_pend));
    end
    svc_done = 1'b0;

    // core_busy blocks delivery; release delivers one cycle later
    do_reset();
    core_busy = 1'b1;
    src_req = 2'b01; src_data[31:0] = 32'hA3A3A3A3;
    tick();
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("busy_hold_irq", 64'(irq), 64'd0);
    end
    core_busy = 1'b0;
    tick();
    chk("busy_release_irq", 64'(irq), 64'd1);
    chk("busy_release_data", 64'(irq_data), 64'hA3A3A3A3);
    src_req = 2'b00;
    finish_service();

    // a flush on the release cycle slips delivery by one
    core_busy = 1'b1;
    src_req = 2'b01; src_data[31:0] = 32'hF1F1F1F1;
    tick();
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("flush_busy_irq", 64'(irq), 64'd0);
    end
    core_busy = 1'b0; core_flush = 1'b1;
    tick();
    chk("flush_block_irq", 64'(irq), 64'd0);
    core_flush = 1'b0;
    tick();
    chk("flush_slip_irq", 64'(irq), 64'd1);
    chk("flush_slip_data", 64'(irq_data), 64'hF1F1F1F1);
    src_req = 2'b00;
    finish_service();

    // dropped edge keeps the first capture; overflow counter saturates
    do_reset();
    core_busy = 1'b1;
    src_req = 2'b01; src_data[31:0] = 32'hAAAA0001;
    tick();
    src_req = 2'b00;
    tick();
    src_req = 2'b01; src_data[31:0] = 32'hBBBB0002;
    tick();
    chk("ovf_one", 64'(ovf_count), 64'd1);
    chk("ovf_pend", 64'(pending), 64'd1);
    core_busy = 1'b0;
    wait_irq(8, "ovf_deliver_irq");
    chk("ovf_first_data", 64'(irq_data), 64'hAAAA0001);
    finish_service();
    core_busy = 1'b1;
    src_req = 2'b00;
    tick();
    src_req = 2'b01;
    tick();
    for (int k = 0; k < 300; k++) begin
      src_req = 2'b00; tick();
      src_req = 2'b01; tick();
    end
    chk("ovf_saturate", 64'(ovf_count), 64'hFF);

    // masked request is held, then delivered once enabled
    do_reset();
    irq_en = 2'b00;
    src_req = 2'b10; src_data[63:32] = 32'h55AA55AA;
    repeat (3) tick();
    chk("mask_pend", 64'(pending), 64'd2);
    chk("mask_irq", 64'(irq), 64'd0);
    chk("mask_insvc", 64'(in_service), 64'd0);
    irq_en = 2'b10;
    tick();
    chk("unmask_wait_irq", 64'(irq), 64'd0);
    tick();
    chk("unmask_irq", 64'(irq), 64'd1);
    chk("unmask_data", 64'(irq_data), 64'h55AA55AA);
    chk("unmask_id", 64'(irq_id), 64'd1);
    src_req = 2'b00;
    finish_service();

    // asynchronous reset in the middle of service
    do_reset();
    src_req = 2'b01; src_data[31:0] = 32'hDEAD0006;
    wait_irq(6, "async_pre_irq");
    tick();
    chk("async_pre_insvc", 64'(in_service), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_irq",   64'(irq),        64'd0);
    chk("async_insvc", 64'(in_service), 64'd0);
    chk("async_pend",  64'(pending),    64'd0);
    chk("async_ovf",   64'(ovf_count),  64'd0);
    chk("async_data",  64'(irq_data),   64'd0);
    @(negedge clk);
    rst = 1'b0; src_req = 2'b00;
    tick();
    src_req = 2'b01; src_data[31:0] = 32'h600D0006;
    repeat (2) tick();
    chk("post_rst_early", 64'(irq), 64'd0);
    tick();
    chk("post_rst_irq", 64'(irq), 64'd1);
    chk("post_rst_data", 64'(irq_data), 64'h600D0006);

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 2; i++)
        if ($urandom_range(0, 2) == 0) src_req[i] = ~src_req[i];
      src_data   = {$urandom(), $urandom()};
      if ($urandom_range(0, 19) == 0) irq_en = 2'($urandom_range(0, 3));
      core_busy  = ($urandom_range(0, 2) == 0);
      core_flush = ($urandom_range(0, 5) == 0);
      svc_done   = ($urandom_range(0, 5) == 0);
      model_step();
      tick();
      chk("rnd_irq",   64'(irq),        64'(m_pulse));
      chk("rnd_insvc", 64'(in_service), 64'(m_pulse || m_serving));
      chk("rnd_id",    64'(irq_id),     64'(m_id));
      chk("rnd_data",  64'(irq_data),   64'(m_data));
      chk("rnd_pend",  64'(pending),    64'({m_pend[1], m_pend[0]}));
      chk("rnd_ovf",   64'(ovf_count),  64'(m_drops));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
